line_mem_responder: RTL
=======================

Name: line_mem_responder

Overview:
- Main-memory responder for the data cache's line-refill and write-back port (ram_en / ram_write / ram_addr / ram_wdata / ram_rdata).
- Accepts one 256-bit line request at a time. Serialises it into eight 32-bit beats on a single-port synchronous word SRAM (1-cycle read latency). Signals completion with a one-cycle ram_ready pulse.
- Sits between the cache and the backing BRAM in the My_CPU top level.

Parameters:
- ADDR_W, 32: width of ram_addr (byte address).
- MEM_AW, 12: word-address width of the backing SRAM.
- BEATS, 8: 32-bit beats per line; fixed at 8 (line = 256 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ram_en  in  1  request valid; held high by the cache until it samples ram_ready=1.
- ram_write  in  1  1 = write-back line, 0 = line refill.
- ram_addr  in  ADDR_W  byte address of the line; bits [4:0] are ignored.
- ram_wdata  in  256  write-back line data.
- ram_rdata  out  256  refill line data; beat k is at [32k+31:32k].
- ram_ready  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after a read issue.

Behaviour:
- Reset values (async): state=IDLE; ram_ready=0; ram_rdata=0; busy=0; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0; beat counter=0.
- Word address for beat k = {ram_addr[MEM_AW+4:5], k[2:0]}, truncated to MEM_AW bits.
- FSM states: IDLE, WR, RD, RD_TAIL, DONE.
- IDLE:
  - On a clock edge with ram_en=1, capture ram_addr, ram_write and ram_wdata into internal registers.
  - Go to WR if ram_write=1, otherwise RD. Counter=0.
  - Input changes after capture are ignored until the next acceptance.
- WR (beat k = 0..7):
  - Drive mem_en=1, mem_we=1, mem_addr = word address of beat k, mem_wdata = captured wdata[32k+31:32k].
  - Counter increments each cycle; after k=7, go to DONE.
- RD (beat k = 0..7):
  - Drive mem_en=1, mem_we=0, mem_addr = word address of beat k.
  - Each cycle with k≥1, store mem_rdata into ram_rdata slice k-1.
  - After k=7, go to RD_TAIL.
- RD_TAIL: mem_en=0; store mem_rdata into slice 7; go to DONE.
- DONE: ram_ready=1 for exactly this cycle; busy=0 from the next cycle; go to IDLE.
- Latency, counted from the acceptance edge E0 with cycle 1 being the first cycle after it:
  - Write: WR occupies cycles 1–8; ram_ready is high in cycle 9.
  - Read: RD occupies cycles 1–8, RD_TAIL cycle 9; ram_ready is high in cycle 10.
- ram_rdata is updated only by slice writes during RD/RD_TAIL. It holds its last value through write-backs and idle periods.
- Slices not yet loaded during a refill keep their old contents. ram_rdata is only guaranteed complete while ram_ready=1.
- Handshake:
  - The cache must drop ram_en on the edge at which it samples ram_ready=1.
  - If ram_en is still 1 in IDLE after DONE, it is treated as a new request (back-to-back requests are legal, one-cycle gap).
- ram_en is ignored while busy. There is no queueing.
- mem_en=0 in IDLE and DONE.
- Reset mid-operation: immediate return to IDLE; any remaining beats are abandoned (SRAM line may be partially written); no ram_ready pulse.
- Address wrap: ram_addr bits above MEM_AW+4 are dropped, so lines alias modulo 2^MEM_AW words.

Test Plan:
1. Write-back then refill round trip:
   - Stimulus: write ram_addr=0x0000_0040, ram_wdata={32'h8..32'h1} (beat k = k+1); then refill the same address.
   - Response: SRAM words 0x10–0x17 hold 1..8; write ram_ready in cycle 9; read ram_ready in cycle 10 with ram_rdata equal to the written line.
2. Offset ignore:
   - Stimulus: refill with ram_addr=0x0000_005F.
   - Response: same SRAM words 0x10–0x17 as address 0x40; identical data.
3. Back-to-back requests:
   - Stimulus: ram_en held high across DONE for two refills.
   - Response: the second request is accepted in the IDLE cycle after DONE; two ram_ready pulses 11 cycles apart.
4. Busy-ignore:
   - Stimulus: change ram_addr and ram_wdata during a WR in progress.
   - Response: SRAM receives only the originally captured data and address.
5. Reset mid-write:
   - Stimulus: assert rst after beat 3 of a write.
   - Response: words 0–3 written, words 4–7 unchanged; outputs at reset values; no ram_ready.
6. Aliasing:
   - Stimulus: MEM_AW=12, write to ram_addr=0x0002_0040.
   - Response: data lands at word 0x10.

Source files
------------

// File: rtl/line_mem_responder.sv
// -----------------------------------------------------------------------------
// line_mem_responder
//
// Main-memory responder for the data cache's line refill / write-back port.
// One 256-bit line request is accepted at a time and serialised into eight
// 32-bit beats on a single-port synchronous word SRAM with 1-cycle read
// latency. Completion is signalled with a one-cycle ram_ready pulse.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   ram_en     request valid, held by the cache until it sees ram_ready
//   ram_write  1 = write-back line, 0 = line refill
//   ram_addr   byte address of the line (bits [4:0] ignored)
//   ram_wdata  write-back line data, beat k at [32k+31:32k]
//   ram_rdata  refill line data, beat k at [32k+31:32k]
//   ram_ready  one-cycle completion pulse
//   busy       high whenever a request is in flight (state != IDLE)
//   mem_en     SRAM access enable
//   mem_we     SRAM write enable
//   mem_addr   SRAM word address
//   mem_wdata  SRAM write data
//   mem_rdata  SRAM read data, valid the cycle after a read issue
// -----------------------------------------------------------------------------
module line_mem_responder #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 12,
    parameter int BEATS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_en,
    input  logic                  ram_write,
    input  logic [ADDR_W-1:0]     ram_addr,
    input  logic [32*BEATS-1:0]   ram_wdata,
    output logic [32*BEATS-1:0]   ram_rdata,
    output logic                  ram_ready,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int LINE_W  = 32 * BEATS;
    // Line index inside the SRAM: word address is {line, beat}, so only the
    // low MEM_AW-3 bits of the line number survive; higher ones alias.
    localparam int LINE_AW = MEM_AW - 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_TAIL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [LINE_AW-1:0]  line_q, line_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [2:0]          prev_beat;

    // Address bits that never reach the SRAM (line offset and aliased high bits).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr[ADDR_W-1:MEM_AW+2], ram_addr[4:0]};

    // Read data for beat k arrives while beat k+1 is being issued.
    assign prev_beat = cnt_q - 3'd1;

    // NOTE: every always_comb output gets a default before the case statement
    // so that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ram_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (ram_en) begin
                    line_d  = ram_addr[MEM_AW+1:5];
                    wdata_d = ram_wdata;
                    cnt_d   = 3'd0;
                    state_d = ram_write ? WR : RD;
                end
            end
            WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_q, cnt_q};
                mem_wdata = wdata_q[{cnt_q, 5'd0} +: 32];
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = DONE;
            end
            RD: begin
                mem_en   = 1'b1;
                mem_addr = {line_q, cnt_q};
                if (cnt_q != 3'd0) rdata_d[{prev_beat, 5'd0} +: 32] = mem_rdata;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = RD_TAIL;
            end
            RD_TAIL: begin
                rdata_d[LINE_W-1 -: 32] = mem_rdata;
                state_d = DONE;
            end
            DONE: begin
                ram_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ram_rdata = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
